// File: rtl/cla_req_arbiter.sv
// cla_req_arbiter: round-robin front end for one shared pipelined 16-bit CLA adder.
// Grants at most one requester per cycle, registers the operands toward the adder,
// and carries the requester ID alongside the adder pipeline so each result returns
// tagged with its originator.
module cla_req_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned LAT  = 3,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [16*NREQ-1:0]   i_req_a,
  input  logic [16*NREQ-1:0]   i_req_b,
  input  logic [NREQ-1:0]      i_req_cin,
  output logic [NREQ-1:0]      o_req_ready,
  output logic [15:0]          o_add_m,
  output logic [15:0]          o_add_n,
  output logic                 o_add_cin,
  input  logic [15:0]          i_add_o,
  input  logic                 i_add_of,
  output logic                 o_rsp_valid,
  output logic [IDW-1:0]       o_rsp_id,
  output logic [15:0]          o_rsp_sum,
  output logic                 o_rsp_of,
  output logic                 o_busy
);

  localparam int unsigned DW = 16;
  localparam int unsigned PW = IDW + 1;
  localparam int unsigned CW = $clog2(LAT + 2);

  // Round-robin pointer and arbitration results
  logic [IDW-1:0]  r_ptr;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [PW-1:0]   w_idx;
  logic            w_found;
  logic [IDW-1:0]  w_gnt_id;
  logic [NREQ-1:0] w_grant;
  logic [DW-1:0]   w_gnt_a;
  logic [DW-1:0]   w_gnt_b;
  logic            w_gnt_cin;

  // Issue stage (aligned with the adder operand registers)
  logic [DW-1:0]   r_add_m;
  logic [DW-1:0]   r_add_n;
  logic            r_add_cin;
  logic            r_iss_vld;
  logic [IDW-1:0]  r_iss_id;

  // Tag delay line following the adder pipeline
  logic [LAT-1:0]  r_tag_vld;
  logic [IDW-1:0]  r_tag_id [LAT];
  logic            w_rsp_fire;

  // Response registers
  logic            r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [DW-1:0]   r_rsp_sum;
  logic            r_rsp_of;

  // In-flight accounting
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic            r_busy;

  // Search from the pointer, wrapping modulo NREQ; first valid index wins
  always_comb begin
    w_grant  = '0;
    w_gnt_id = '0;
    w_found  = 1'b0;
    w_idx    = '0;
    for (int unsigned off = 0; off < NREQ; off++) begin
      w_idx = {1'b0, r_ptr} + PW'(off);
      if (w_idx >= PW'(NREQ)) begin
        w_idx = w_idx - PW'(NREQ);
      end
      if (!w_found && i_req_valid[w_idx[IDW-1:0]]) begin
        w_found                   = 1'b1;
        w_gnt_id                  = w_idx[IDW-1:0];
        w_grant[w_idx[IDW-1:0]]   = 1'b1;
      end
    end
    // No grant may be offered while the block is held in reset
    if (!rst_n) begin
      w_grant = '0;
      w_found = 1'b0;
    end
  end

  // Operand mux driven by the one-hot grant
  always_comb begin
    w_gnt_a   = '0;
    w_gnt_b   = '0;
    w_gnt_cin = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_gnt_a   = i_req_a[i*DW +: DW];
        w_gnt_b   = i_req_b[i*DW +: DW];
        w_gnt_cin = i_req_cin[i];
      end
    end
  end

  // Pointer moves just past the winner so it becomes lowest priority next
  always_comb begin
    w_ptr_nxt = w_gnt_id + IDW'(1);
    if (w_gnt_id == IDW'(NREQ - 1)) begin
      w_ptr_nxt = '0;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_found) begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Operand registers hold their value when nothing is issued
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_add_m   <= '0;
      r_add_n   <= '0;
      r_add_cin <= 1'b0;
    end else if (w_found) begin
      r_add_m   <= w_gnt_a;
      r_add_n   <= w_gnt_b;
      r_add_cin <= w_gnt_cin;
    end
  end

  // Stage 0 of the tag line, loaded on the same edge as the operands
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iss_vld <= 1'b0;
      r_iss_id  <= '0;
    end else begin
      r_iss_vld <= w_found;
      r_iss_id  <= w_gnt_id;
    end
  end

  // Remaining tag stages; the last one is valid while the adder output matches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_vld <= '0;
      for (int unsigned s = 0; s < LAT; s++) begin
        r_tag_id[s] <= '0;
      end
    end else begin
      r_tag_vld[0] <= r_iss_vld;
      r_tag_id[0]  <= r_iss_id;
      for (int unsigned s = 1; s < LAT; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
    end
  end

  assign w_rsp_fire = r_tag_vld[LAT-1];

  // Capture the adder result with its tag; payload holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_sum   <= '0;
      r_rsp_of    <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_fire;
      if (w_rsp_fire) begin
        r_rsp_id  <= r_tag_id[LAT-1];
        r_rsp_sum <= i_add_o;
        r_rsp_of  <= i_add_of;
      end
    end
  end

  // Next in-flight count: +1 on issue, -1 on response, both cancel
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_found && !w_rsp_fire) begin
      w_cnt_nxt = r_cnt + CW'(1);
    end else if (!w_found && w_rsp_fire) begin
      w_cnt_nxt = r_cnt - CW'(1);
    end
  end

  // In-flight counter and registered busy flag derived from it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      r_busy <= (w_cnt_nxt != '0);
    end
  end

  assign o_req_ready = w_grant;
  assign o_add_m     = r_add_m;
  assign o_add_n     = r_add_n;
  assign o_add_cin   = r_add_cin;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_rsp_sum   = r_rsp_sum;
  assign o_rsp_of    = r_rsp_of;
  assign o_busy      = r_busy;

endmodule

// File: tb/tb_cla_req_arbiter.sv
// Bench for cla_req_arbiter: behavioural pipelined adder plus a queue-based
// expectation model for grants, issue operands, tagged responses and busy.
module tb_cla_req_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned LAT  = 3;
  localparam int unsigned IDW  = 2;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req_valid;
  logic [16*NREQ-1:0] req_a;
  logic [16*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_cin;
  logic [NREQ-1:0]    req_ready;
  logic [15:0]        add_m;
  logic [15:0]        add_n;
  logic               add_cin;
  logic [15:0]        add_o;
  logic               add_of;
  logic               rsp_valid;
  logic [IDW-1:0]     rsp_id;
  logic [15:0]        rsp_sum;
  logic               rsp_of;
  logic               busy;

  cla_req_arbiter #(.NREQ(NREQ), .LAT(LAT), .IDW(IDW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (req_valid),
    .i_req_a     (req_a),
    .i_req_b     (req_b),
    .i_req_cin   (req_cin),
    .o_req_ready (req_ready),
    .o_add_m     (add_m),
    .o_add_n     (add_n),
    .o_add_cin   (add_cin),
    .i_add_o     (add_o),
    .i_add_of    (add_of),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_sum   (rsp_sum),
    .o_rsp_of    (rsp_of),
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared CLA adder: LAT-cycle pipeline, {Of, O}
  logic [16:0] pipe [LAT];

  function automatic logic [16:0] add_fn(input logic [15:0] m, input logic [15:0] n, input logic c);
    logic [15:0] s;
    s = m + n + 16'(c);
    return {(m[15] == n[15]) && (s[15] != m[15]), s};
  endfunction

  always @(posedge clk) begin
    pipe[0] <= add_fn(add_m, add_n, add_cin);
    for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
  end

  assign add_o  = pipe[LAT-1][15:0];
  assign add_of = pipe[LAT-1][16];

  typedef struct {
    int          id;
    logic [15:0] sum;
    logic        of;
    int          due;
  } exp_t;

  exp_t q[$];
  int   ptr;
  int   cyc;
  int   checks;
  int   errors;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [15:0] a, input logic [15:0] b, input logic c);
    req_valid[i]      = v;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
    req_cin[i]        = c;
  endtask

  task automatic rnd_req(input int i, input logic v);
    set_req(i, v, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
  endtask

  // Expected grant: first valid index scanning upward from ptr, wrapping
  function automatic logic [NREQ-1:0] model_grant();
    logic [NREQ-1:0] r;
    int idx;
    r = '0;
    for (int off = 0; off < NREQ; off++) begin
      idx = (ptr + off) % NREQ;
      if (req_valid[idx]) begin
        r[idx] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  // One clock cycle: check grant before the edge, model the transfer, check outputs after
  task automatic step(output int g);
    logic [NREQ-1:0] eg;
    logic [15:0]     va;
    logic [15:0]     vb;
    logic            vc;
    int              tot;
    exp_t            e;
    @(negedge clk);
    eg = model_grant();
    chk("req_ready", 32'(req_ready), 32'(eg));
    g  = -1;
    va = '0;
    vb = '0;
    vc = 1'b0;
    for (int i = 0; i < NREQ; i++) if (eg[i]) g = i;
    if (g >= 0) begin
      va    = req_a[16*g +: 16];
      vb    = req_b[16*g +: 16];
      vc    = req_cin[g];
      tot   = int'($signed(va)) + int'($signed(vb)) + int'(vc);
      e.id  = g;
      e.sum = 16'(tot);
      e.of  = (tot > 32767) || (tot < -32768);
    end
    @(posedge clk);
    cyc++;
    if (g >= 0) begin
      e.due = cyc + LAT + 1;
      q.push_back(e);
      ptr = (g + 1) % NREQ;
    end
    #1;
    if (g >= 0) begin
      chk("add_m", 32'(add_m), 32'(va));
      chk("add_n", 32'(add_n), 32'(vb));
      chk("add_cin", 32'(add_cin), 32'(vc));
    end
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rsp_id", 32'(rsp_id), 32'(e.id));
      chk("rsp_sum", 32'(rsp_sum), 32'(e.sum));
      chk("rsp_of", 32'(rsp_of), 32'(e.of));
    end else begin
      chk("rsp_idle", 32'(rsp_valid), 32'd0);
    end
    chk("busy", 32'(busy), 32'(q.size() != 0));
  endtask

  int g;
  int gseq[$];
  int gap;
  int maxgap;
  int exp_seq[6];

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    ptr       = 0;
    rst_n     = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    req_cin   = '0;

    // Reset values, with requests pending to confirm grants are suppressed
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_add_m", 32'(add_m), 32'd0);
    chk("rst_add_n", 32'(add_n), 32'd0);
    chk("rst_add_cin", 32'(add_cin), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("rst_rsp_of", 32'(rsp_of), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    req_valid = '0;
    rst_n     = 1'b1;

    // Idle
    repeat (10) step(g);

    // Single request from requester 2
    set_req(2, 1'b1, 16'hAACD, 16'hBBDE, 1'b0);
    step(g);
    chk("single_grant", 32'(g), 32'd2);
    req_valid[2] = 1'b0;
    repeat (LAT + 2) step(g);

    // Move the pointer back to 0 with a lone request from 3
    rnd_req(3, 1'b1);
    step(g);
    chk("wrap_grant", 32'(g), 32'd3);
    req_valid = '0;

    // All four continuously valid: strict rotation
    for (int i = 0; i < NREQ; i++) rnd_req(i, 1'b1);
    exp_seq = '{0, 1, 2, 3, 0, 1};
    repeat (6) begin
      step(g);
      gseq.push_back(g);
      if (g >= 0) rnd_req(g, 1'b1);
    end
    req_valid = '0;
    for (int i = 0; i < 6; i++) chk("rr_order", 32'(gseq[i]), 32'(exp_seq[i]));
    repeat (LAT + 2) step(g);

    // Tagging: requester 1 then requester 3 back-to-back
    set_req(1, 1'b1, 16'h1234, 16'h4321, 1'b0);
    step(g);
    chk("tag_grant1", 32'(g), 32'd1);
    req_valid[1] = 1'b0;
    set_req(3, 1'b1, 16'h6789, 16'h9876, 1'b0);
    step(g);
    chk("tag_grant3", 32'(g), 32'd3);
    req_valid[3] = 1'b0;
    repeat (LAT + 2) step(g);

    // Fairness: 0 held valid, 2 valid every cycle
    rnd_req(0, 1'b1);
    rnd_req(2, 1'b1);
    gap    = 0;
    maxgap = 0;
    repeat (50) begin
      step(g);
      if (g == 0) gap = 0;
      else gap++;
      if (gap > maxgap) maxgap = gap;
      if (g >= 0) rnd_req(g, 1'b1);
    end
    chk("fair_maxgap", 32'(maxgap), 32'd1);
    req_valid = '0;
    repeat (LAT + 2) step(g);

    // Reset mid-flight: three issues, reset one cycle after the third
    for (int i = 0; i < 3; i++) begin
      rnd_req(i, 1'b1);
      step(g);
      chk("mf_grant", 32'(g), 32'(i));
      req_valid[i] = 1'b0;
    end
    step(g);
    req_valid[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("mf_busy", 32'(busy), 32'd0);
    chk("mf_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mf_rsp_sum", 32'(rsp_sum), 32'd0);
    chk("mf_rsp_id", 32'(rsp_id), 32'd0);
    chk("mf_add_m", 32'(add_m), 32'd0);
    chk("mf_add_n", 32'(add_n), 32'd0);
    chk("mf_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("mf_ready_neg", 32'(req_ready), 32'd0);
    @(posedge clk);
    cyc++;
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    q.delete();
    ptr = 0;
    repeat (LAT + 2) step(g);

    // Randomized traffic; requesters hold until granted
    for (int i = 0; i < NREQ; i++) rnd_req(i, 1'($urandom_range(0, 1)));
    repeat (400) begin
      step(g);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] || i == g) rnd_req(i, ($urandom_range(0, 9) < 6));
      end
    end
    req_valid = '0;
    repeat (LAT + 3) step(g);
    chk("drain_empty", 32'(q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cla_req_arbiter.md
Name: cla_req_arbiter

Overview:
- Round-robin arbiter that shares one pipelined 16-bit carry-lookahead adder (CLAout) between NREQ requesters.
- Accepts at most one add request per cycle and drives the adder operand and carry-in inputs from registers.
- Tracks each issued operation's requester ID through a tag delay line matched to the adder latency.
- Returns sum and overflow tagged with the originating requester. Sits between client blocks and the shared adder instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LAT, 3, adder latency in cycles: add_m/add_n change at edge e, and the matching add_o/add_of are valid after edge e+LAT.
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.

Ports:
- clk, in, 1, system clock; all state updates on rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- req_valid, in, NREQ, per-requester request valid.
- req_a, in, 16*NREQ, operand A; requester i occupies bits [16i+15:16i].
- req_b, in, 16*NREQ, operand B, same packing as req_a.
- req_cin, in, NREQ, carry-in per requester.
- req_ready, out, NREQ, one-hot grant (combinational); transfer occurs when req_valid[i] & req_ready[i].
- add_m, out, 16, adder operand M (registered).
- add_n, out, 16, adder operand N (registered).
- add_cin, out, 1, adder carry-in C_in (registered).
- add_o, in, 16, adder sum O.
- add_of, in, 1, adder overflow Of.
- rsp_valid, out, 1, response valid (registered, one-cycle pulse per result).
- rsp_id, out, IDW, requester index of the response.
- rsp_sum, out, 16, captured add_o.
- rsp_of, out, 1, captured add_of.
- busy, out, 1, high while any operation is in flight.

Behaviour:
- Reset (async, rst_n=0):
  - add_m=0, add_n=0, add_cin=0; rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_of=0, busy=0.
  - Round-robin pointer=0; tag line and in-flight counter cleared.
- Arbitration:
  - Search req_valid starting at pointer index, wrapping modulo NREQ; the first asserted index gets req_ready.
  - req_ready is all-zero when no req_valid is asserted or while rst_n=0.
  - req_ready may depend on req_valid; requesters must hold valid, a, b and cin stable until granted.
- Pointer update:
  - On a transfer from index g, the pointer becomes (g+1) mod NREQ.
  - With no transfer, the pointer holds.
  - Guarantee: a continuously valid requester is granted within NREQ cycles.
- Issue:
  - On a transfer at edge k, add_m/add_n/add_cin load the granted operands.
  - The tag line loads {valid=1, id=g} at stage 0.
  - With no transfer, add_* hold their previous values and the tag line loads {valid=0}.
- Tag line:
  - Shift register aligned so that stage LAT-1 is valid exactly when add_o/add_of correspond to the tagged issue.
- Response:
  - A transfer at edge k produces, at edge k+LAT+1: rsp_valid=1, rsp_id=g, rsp_sum=add_o, rsp_of=add_of.
  - rsp_valid is otherwise 0; rsp_id/rsp_sum/rsp_of hold their last values.
  - There is no response backpressure; consumers must accept every pulse.
- Throughput and ordering:
  - One issue per cycle sustained; back-to-back responses on consecutive cycles.
  - Responses return in issue order.
- In-flight counter:
  - Width clog2(LAT+2). Increments on issue and decrements on response.
  - Simultaneous issue and response leaves it unchanged.
  - busy = (count != 0).
- Arithmetic:
  - The arbiter performs no arithmetic. rsp_sum and rsp_of pass through the adder result bit-exact, with no width change.
- Reset mid-operation: all in-flight operations are discarded and no rsp_valid is produced for them afterward.
- Single requester with NREQ>1: granted every cycle it is valid, regardless of pointer position.

Test Plan:
- Reset then idle, NREQ=4, LAT=3, all req_valid=0 for 10 cycles -> req_ready=0000, rsp_valid never asserts, busy=0.
- Single request: req 2 with a=0xAACD, b=0xBBDE, cin=0, accepted at edge k -> req_ready=0100 before edge k; rsp_valid at edge k+4 only, rsp_id=2, rsp_sum=0x66AB, rsp_of equals the adder's Of; busy high from k to k+4.
- Round robin: all four valid continuously from pointer 0 -> grants in order 0,1,2,3,0,1; responses on consecutive cycles with ids 0,1,2,3,0,1.
- Tagging: req 1 (0x1234+0x4321, cin=0) then req 3 (0x6789+0x9876, cin=0) back-to-back -> rsp (id=1, 0x5555) then (id=3, 0xFFFF) on consecutive cycles.
- Fairness: req 0 held valid while req 2 pulses every cycle -> req 0 granted on at least every other cycle; no starvation over 50 cycles.
- Reset mid-flight: three requests issued, rst_n pulsed low one cycle after the third -> outputs at reset values immediately, busy=0, no rsp_valid for the dropped operations over the following LAT+2 cycles.
